// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter.
package wb_pkg;
  localparam int REQ_INT  = 0;
  localparam int REQ_FP   = 1;
  localparam int REQ_AGU  = 2;
  localparam int NREQ     = 3;
  localparam int RD_W     = 5;
  localparam int WB_XLEN  = 32;   // slot data width; top-level XLEN must match
  localparam int ONEHOT_W = 32;   // 1 << RD_W

  typedef struct packed {
    logic               full;
    logic [RD_W-1:0]    rd;
    logic               fp;
    logic [WB_XLEN-1:0] data;
  } slot_t;

  function automatic logic [ONEHOT_W-1:0] onehot(input logic [RD_W-1:0] idx);
    logic [ONEHOT_W-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/wb_arbiter_rr.sv
// Three-way round-robin arbiter; the pointer names the highest-priority requester.
module rr_arbiter3 import wb_pkg::*; (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [1:0]      gidx
);
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] cand;

  function automatic logic [1:0] wrap3(input logic [2:0] v);
    return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
  endfunction

  // First requester at or after ptr wins, scanning ptr, ptr+1, ptr+2 (mod 3)
  always_comb begin
    grant = '0;
    gidx  = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = wrap3({1'b0, ptr_q} + 3'(k));
      if (grant == '0 && req[cand]) begin
        grant[cand] = 1'b1;
        gidx        = cand;
      end
    end
  end

  // Pointer moves just past the winner; holds when nothing is granted
  always_comb begin
    ptr_d = ptr_q;
    if (grant != '0) ptr_d = wrap3({1'b0, gidx} + 3'd1);
  end

  // Pointer register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: one holding slot per execution unit, round-robin drain
// into a registered writeback stage driving one-hot register-file enables.
module wb_arbiter import wb_pkg::*; #(
  parameter int XLEN = WB_XLEN,
  parameter int NREG = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*RD_W-1:0] req_rd,
  input  logic [NREQ-1:0]      req_fp,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic                 wb_valid,
  output logic [1:0]           wb_src,
  output logic [RD_W-1:0]      wb_rd,
  output logic [XLEN-1:0]      wb_data,
  output logic [NREG-1:0]      R_in,
  output logic [NREG-1:0]      Fp_in,
  output logic [NREG-1:0]      busy_clr
);
  slot_t slot_q [NREQ];
  slot_t slot_d [NREQ];

  logic [NREQ-1:0]     full;
  logic [NREQ-1:0]     grant;
  logic [1:0]          gidx;

  logic                wb_valid_q, wb_valid_d;
  logic [1:0]          wb_src_q,   wb_src_d;
  logic [RD_W-1:0]     wb_rd_q,    wb_rd_d;
  logic                wb_fp_q,    wb_fp_d;
  logic [XLEN-1:0]     wb_data_q,  wb_data_d;
  logic [ONEHOT_W-1:0] oh;

  // Occupancy vector feeds the scheduler
  always_comb begin
    for (int i = 0; i < NREQ; i++) full[i] = slot_q[i].full;
  end

  rr_arbiter3 u_rr (
    .clk   (clk),
    .reset (reset),
    .req   (full),
    .grant (grant),
    .gidx  (gidx)
  );

  // A slot is free if empty or being drained now; never depends on req_valid
  always_comb begin
    for (int i = 0; i < NREQ; i++) req_ready[i] = !slot_q[i].full || grant[i];
  end

  // Slot update: drain on grant, a same-cycle refill overrides the clear
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      slot_d[i] = slot_q[i];
      if (grant[i]) slot_d[i].full = 1'b0;
      if (req_valid[i] && req_ready[i]) begin
        slot_d[i].full = 1'b1;
        slot_d[i].rd   = req_rd[i*RD_W +: RD_W];
        slot_d[i].fp   = req_fp[i];
        slot_d[i].data = req_data[i*XLEN +: XLEN];
      end
    end
  end

  // Writeback stage input: winner's fields; data fields hold when idle
  always_comb begin
    wb_valid_d = |grant;
    wb_src_d   = wb_src_q;
    wb_rd_d    = wb_rd_q;
    wb_fp_d    = wb_fp_q;
    wb_data_d  = wb_data_q;
    if (|grant) wb_src_d = gidx;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        wb_rd_d   = slot_q[i].rd;
        wb_fp_d   = slot_q[i].fp;
        wb_data_d = slot_q[i].data;
      end
    end
  end

  // Slot and writeback registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) slot_q[i] <= '0;
      wb_valid_q <= 1'b0;
      wb_src_q   <= '0;
      wb_rd_q    <= '0;
      wb_fp_q    <= 1'b0;
      wb_data_q  <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) slot_q[i] <= slot_d[i];
      wb_valid_q <= wb_valid_d;
      wb_src_q   <= wb_src_d;
      wb_rd_q    <= wb_rd_d;
      wb_fp_q    <= wb_fp_d;
      wb_data_q  <= wb_data_d;
    end
  end

  // Enable decode; x0 writes are absorbed, f0 is a real register
  always_comb begin
    oh    = onehot(wb_rd_q);
    R_in  = '0;
    Fp_in = '0;
    if (wb_valid_q) begin
      if (wb_fp_q)              Fp_in = oh[NREG-1:0];
      else if (wb_rd_q != '0)   R_in  = oh[NREG-1:0];
    end
  end

  assign busy_clr = R_in;
  assign wb_valid = wb_valid_q;
  assign wb_src   = wb_src_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter.
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid, req_ready, req_fp;
  logic [14:0] req_rd;
  logic [95:0] req_data;
  logic        wb_valid;
  logic [1:0]  wb_src;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] R_in, Fp_in, busy_clr;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd),
    .req_fp(req_fp), .req_data(req_data),
    .wb_valid(wb_valid), .wb_src(wb_src), .wb_rd(wb_rd), .wb_data(wb_data),
    .R_in(R_in), .Fp_in(Fp_in), .busy_clr(busy_clr)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] rd, input logic fp, input logic [31:0] d);
    req_rd[i*5 +: 5]    = rd;
    req_fp[i]           = fp;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic do_reset();
    req_valid = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '0; req_rd = '0; req_fp = '0; req_data = '0;
    #3;
    checks++; if (wb_valid !== 1'b0)     begin errors++; $display("FAIL rst_wb_valid: got %0h exp 0", wb_valid); end
    checks++; if (req_ready !== 3'b111)  begin errors++; $display("FAIL rst_ready: got %b exp 111", req_ready); end
    checks++; if (R_in !== '0 || Fp_in !== '0 || busy_clr !== '0)
      begin errors++; $display("FAIL rst_enables: R_in %0h Fp_in %0h busy_clr %0h exp 0", R_in, Fp_in, busy_clr); end
    checks++; if (wb_src !== 2'd0 || wb_rd !== 5'd0 || wb_data !== 32'd0)
      begin errors++; $display("FAIL rst_wb_fields: src %0d rd %0d data %0h exp 0", wb_src, wb_rd, wb_data); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_single_int();
    set_req(0, 5'd5, 1'b0, 32'hDEADBEEF);
    req_valid = 3'b001;
    tick();
    req_valid = '0;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL single_lat1: wb_valid %0h exp 0", wb_valid); end
    tick();
    checks++; if (wb_valid !== 1'b1 || wb_src !== 2'd0) begin errors++; $display("FAIL single_wb: valid %0h src %0d exp 1/0", wb_valid, wb_src); end
    checks++; if (R_in !== 32'h20 || busy_clr !== 32'h20 || Fp_in !== '0)
      begin errors++; $display("FAIL single_en: R_in %0h busy_clr %0h Fp_in %0h exp 20/20/0", R_in, busy_clr, Fp_in); end
    checks++; if (wb_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data: got %0h exp deadbeef", wb_data); end
    tick();
    checks++; if (wb_valid !== 1'b0 || R_in !== '0) begin errors++; $display("FAIL single_pulse: valid %0h R_in %0h exp 0/0", wb_valid, R_in); end
  endtask

  task automatic test_x0_f0();
    set_req(0, 5'd0, 1'b0, 32'h1234);
    req_valid = 3'b001;
    tick(); req_valid = '0; tick();
    checks++; if (wb_valid !== 1'b1 || R_in !== '0 || busy_clr !== '0 || wb_data !== 32'h1234)
      begin errors++; $display("FAIL x0: valid %0h R_in %0h busy_clr %0h data %0h exp 1/0/0/1234", wb_valid, R_in, busy_clr, wb_data); end
    set_req(1, 5'd0, 1'b1, 32'h3F800000);
    req_valid = 3'b010;
    tick(); req_valid = '0; tick();
    checks++; if (wb_valid !== 1'b1 || wb_src !== 2'd1 || Fp_in !== 32'h1 || R_in !== '0 || busy_clr !== '0)
      begin errors++; $display("FAIL f0: valid %0h src %0d Fp_in %0h R_in %0h busy_clr %0h exp 1/1/1/0/0", wb_valid, wb_src, Fp_in, R_in, busy_clr); end
    tick();
  endtask

  task automatic test_contention(input logic [1:0] s0, input logic [1:0] s1, input logic [1:0] s2);
    logic [1:0] seq [3];
    seq[0] = s0; seq[1] = s1; seq[2] = s2;
    set_req(0, 5'd1, 1'b0, 32'hA0000000);
    set_req(1, 5'd2, 1'b1, 32'hA0000001);
    set_req(2, 5'd3, 1'b0, 32'hA0000002);
    req_valid = 3'b111;
    tick();
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (wb_valid !== 1'b1 || wb_src !== seq[k] || wb_rd !== 5'(seq[k] + 2'd1) || wb_data !== (32'hA0000000 | 32'(seq[k])))
        begin errors++; $display("FAIL contention_%0d: valid %0h src %0d rd %0d data %0h exp src %0d", k, wb_valid, wb_src, wb_rd, wb_data, seq[k]); end
    end
    tick();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL contention_idle: wb_valid %0h exp 0", wb_valid); end
  endtask

  task automatic test_back_to_back();
    int n_int = 0, n_agu = 0, e_int = 0, e_agu = 0;
    logic [1:0] prev = '0;
    logic prev_v = 1'b0;
    logic a_int, a_agu;
    do_reset();
    set_req(0, 5'd7, 1'b0, 32'h100);
    set_req(2, 5'd9, 1'b0, 32'h200);
    req_valid = 3'b101;
    for (int c = 0; c < 16; c++) begin
      if (c >= 12) req_valid = '0;
      a_int = req_valid[0] & req_ready[0];
      a_agu = req_valid[2] & req_ready[2];
      if (c < 12) begin
        checks++; if (!(req_ready[0] | req_ready[2])) begin errors++; $display("FAIL b2b_ready c%0d: got %b exp a drained slot ready", c, req_ready); end
      end
      tick();
      if (a_int) begin n_int++; set_req(0, 5'd7, 1'b0, 32'h100 + 32'(n_int)); end
      if (a_agu) begin n_agu++; set_req(2, 5'd9, 1'b0, 32'h200 + 32'(n_agu)); end
      if (wb_valid) begin
        checks++;
        if (wb_src == 2'd0) begin
          if (wb_data !== 32'h100 + 32'(e_int) || R_in !== 32'h80) begin errors++; $display("FAIL b2b_int_data: got %0h R_in %0h exp %0h/80", wb_data, R_in, 32'h100 + 32'(e_int)); end
          e_int++;
        end else if (wb_src == 2'd2) begin
          if (wb_data !== 32'h200 + 32'(e_agu) || R_in !== 32'h200) begin errors++; $display("FAIL b2b_agu_data: got %0h R_in %0h exp %0h/200", wb_data, R_in, 32'h200 + 32'(e_agu)); end
          e_agu++;
        end else begin
          errors++; $display("FAIL b2b_src: got %0d exp 0 or 2", wb_src);
        end
        if (prev_v) begin
          checks++; if (wb_src === prev) begin errors++; $display("FAIL b2b_alternate: src %0d repeated", wb_src); end
        end
        prev = wb_src; prev_v = 1'b1;
      end else prev_v = 1'b0;
    end
    checks++; if (n_int !== 7 || n_agu !== 6) begin errors++; $display("FAIL b2b_accepts: int %0d agu %0d exp 7/6", n_int, n_agu); end
    checks++; if (e_int !== n_int || e_agu !== n_agu) begin errors++; $display("FAIL b2b_count: wrote %0d/%0d exp %0d/%0d", e_int, e_agu, n_int, n_agu); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    set_req(0, 5'd4, 1'b0, 32'h11);
    set_req(1, 5'd5, 1'b1, 32'h22);
    set_req(2, 5'd6, 1'b0, 32'h33);
    req_valid = 3'b111;
    tick();
    req_valid = '0;
    tick();
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL mid_pre: wb_valid %0h exp 1", wb_valid); end
    #1 reset = 1'b1;
    #1;
    checks++; if (wb_valid !== 1'b0 || R_in !== '0 || Fp_in !== '0 || req_ready !== 3'b111)
      begin errors++; $display("FAIL mid_async: valid %0h R_in %0h Fp_in %0h ready %b exp 0/0/0/111", wb_valid, R_in, Fp_in, req_ready); end
    #1 reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (wb_valid !== 1'b0 || req_ready !== 3'b111) begin errors++; $display("FAIL mid_stale_%0d: valid %0h ready %b exp 0/111", k, wb_valid, req_ready); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_int();
    test_x0_f0();
    do_reset();
    test_contention(2'd0, 2'd1, 2'd2);
    test_single_int();
    test_contention(2'd1, 2'd2, 2'd0);
    test_back_to_back();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
